// File: rtl/multiply16_if.sv
// Request/response bundle for the multiply16 sequential Booth multiplier.
// The controller drives the master side; the multiplier owns the slave side.
interface multiply16_if #(
  parameter int unsigned WIDTH = 16
) ();

  logic                   start;
  logic [WIDTH-1:0]       multiplicand;
  logic [WIDTH-1:0]       multiplier;
  logic [2*WIDTH-1:0]     product;
  logic                   busy;
  logic                   done;

  modport master (
    output start,
    output multiplicand,
    output multiplier,
    input  product,
    input  busy,
    input  done
  );

  modport slave (
    input  start,
    input  multiplicand,
    input  multiplier,
    output product,
    output busy,
    output done
  );

endinterface

// File: rtl/multiply16.sv
// Sequential signed WIDTHxWIDTH radix-2 Booth multiplier.
// One Booth step per clock. The full 2*WIDTH product is registered at the
// last step and accompanied by a one-cycle done pulse. A start in the DONE
// cycle is accepted, so back-to-back operations run with no idle gap.
module multiply16 #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  multiply16_if.slave      bus
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  // A carries one extra bit so that subtracting M = -2^(WIDTH-1) cannot overflow.
  logic [WIDTH:0]       a_q, a_d;
  logic [WIDTH:0]       m_q, m_d;
  logic [WIDTH-1:0]     q_q, q_d;
  logic                 qm1_q, qm1_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   product_q, product_d;

  // Booth step datapath signals
  logic [WIDTH:0]       a_sum;
  logic [WIDTH:0]       a_sh;
  logic [WIDTH-1:0]     q_sh;
  logic                 qm1_sh;

  // Booth add/subtract on {Q[0], q_-1}, then arithmetic shift of {A, Q, q_-1}
  always_comb begin
    a_sum = a_q;
    unique case ({q_q[0], qm1_q})
      2'b01:   a_sum = a_q + m_q;
      2'b10:   a_sum = a_q - m_q;
      default: a_sum = a_q;
    endcase
    {a_sh, q_sh, qm1_sh} = {a_sum[WIDTH], a_sum, q_q};
  end

  // Next-state and datapath load/step control
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    m_d       = m_q;
    q_d       = q_q;
    qm1_d     = qm1_q;
    cnt_d     = cnt_q;
    product_d = product_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = RUN;
          m_d     = {bus.multiplicand[WIDTH-1], bus.multiplicand};
          q_d     = bus.multiplier;
          qm1_d   = 1'b0;
          a_d     = '0;
          cnt_d   = '0;
        end
      end

      RUN: begin
        // start is deliberately not examined here: requests in flight are dropped
        a_d   = a_sh;
        q_d   = q_sh;
        qm1_d = qm1_sh;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_STEP) begin
          state_d   = DONE;
          product_d = {a_sh[WIDTH-1:0], q_sh};
        end
      end

      DONE: begin
        if (bus.start) begin
          state_d = RUN;
          m_d     = {bus.multiplicand[WIDTH-1], bus.multiplicand};
          q_d     = bus.multiplier;
          qm1_d   = 1'b0;
          a_d     = '0;
          cnt_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      a_q       <= '0;
      m_q       <= '0;
      q_q       <= '0;
      qm1_q     <= 1'b0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      m_q       <= m_d;
      q_q       <= q_d;
      qm1_q     <= qm1_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  // Outputs come straight from flops: no combinational path from inputs
  assign bus.product = product_q;
  assign bus.busy    = (state_q == RUN);
  assign bus.done    = (state_q == DONE);

endmodule

// File: tb/tb_multiply16.sv
// Directed self-checking bench for multiply16 with hand-computed products.
module tb_multiply16;

  logic clk;
  logic rst;
  int unsigned checks;
  int unsigned errors;

  multiply16_if #(.WIDTH(16)) bus ();

  multiply16 #(.WIDTH(16)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Pulse start for one edge, then count edges until done (bounded)
  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic [31:0] exp);
    int cycles;
    bus.multiplicand = a;
    bus.multiplier   = b;
    bus.start        = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check({tag, "_busy"}, {31'd0, bus.busy}, 32'd1);
    cycles = 0;
    while (bus.done !== 1'b1 && cycles < 40) begin
      @(negedge clk);
      cycles++;
    end
    check({tag, "_lat"}, cycles, 32'd16);
    check({tag, "_prod"}, bus.product, exp);
    check({tag, "_nbusy"}, {31'd0, bus.busy}, 32'd0);
    @(negedge clk);
    check({tag, "_dfall"}, {31'd0, bus.done}, 32'd0);
    check({tag, "_hold"}, bus.product, exp);
  endtask

  initial begin
    int cycles;
    int done_cnt;
    int done_at;
    int busy_bad;
    int hold_bad;
    logic [31:0] cap;

    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.multiplicand = '0;
    bus.multiplier = '0;
    @(negedge clk);
    @(negedge clk);
    check("rst_prod", bus.product, 32'h0);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_done", {31'd0, bus.done}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Basic signs
    run_op("p10x2",   16'sd10,  16'sd2,  32'h00000014);
    run_op("m15x3",   -16'sd15, 16'sd3,  32'hFFFFFFD3);
    run_op("m20xm4",  -16'sd20, -16'sd4, 32'h00000050);
    run_op("p90xm7",  16'sd90,  -16'sd7, 32'hFFFFFD8A);

    // Extremes
    run_op("minxmin", 16'h8000, 16'h8000, 32'h40000000);
    run_op("minxmax", 16'h8000, 16'h7FFF, 32'hC0008000);
    run_op("maxxmax", 16'h7FFF, 16'h7FFF, 32'h3FFF0001);
    run_op("zerox1",  16'd0,    16'd1,    32'h00000000);

    // Operand change and extra start while running
    bus.multiplicand = 16'd7;
    bus.multiplier   = 16'd6;
    bus.start        = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    done_cnt = 0; done_at = -1; busy_bad = 0; cap = '0;
    for (int c = 1; c <= 22; c++) begin
      if (c == 3) begin
        bus.multiplicand = 16'd100;
        bus.multiplier   = 16'd100;
        bus.start        = 1'b1;
      end
      if (c == 4) bus.start = 1'b0;
      @(negedge clk);
      if (c < 16 && bus.busy !== 1'b1) busy_bad++;
      if (bus.done === 1'b1) begin
        done_cnt++;
        if (done_at < 0) begin
          done_at = c;
          cap = bus.product;
        end
      end
    end
    check("hyg_prod", cap, 32'h0000002A);
    check("hyg_lat", done_at, 32'd16);
    check("hyg_ndone", done_cnt, 32'd1);
    check("hyg_busy", busy_bad, 32'd0);

    // Reset in the middle of an operation
    bus.multiplicand = 16'd1000;
    bus.multiplier   = 16'd1000;
    bus.start        = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int c = 1; c < 8; c++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mrst_busy", {31'd0, bus.busy}, 32'd0);
    check("mrst_done", {31'd0, bus.done}, 32'd0);
    check("mrst_prod", bus.product, 32'h0);
    run_op("p3xm3", 16'sd3, -16'sd3, 32'hFFFFFFF7);

    // Back-to-back with start held high
    bus.multiplicand = 16'sd5;
    bus.multiplier   = 16'sd5;
    bus.start        = 1'b1;
    @(negedge clk);
    cycles = 0;
    while (bus.done !== 1'b1 && cycles < 40) begin
      @(negedge clk);
      cycles++;
    end
    check("b2b1_lat", cycles, 32'd16);
    check("b2b1_prod", bus.product, 32'h00000019);
    bus.multiplicand = -16'sd2;
    bus.multiplier   = 16'sd4;
    cycles = 0; hold_bad = 0;
    @(negedge clk);
    cycles++;
    while (bus.done !== 1'b1 && cycles < 40) begin
      if (bus.product !== 32'h00000019) hold_bad++;
      @(negedge clk);
      cycles++;
    end
    bus.start = 1'b0;
    check("b2b_gap", cycles, 32'd17);
    check("b2b_hold", hold_bad, 32'd0);
    check("b2b2_prod", bus.product, 32'hFFFFFFF8);
    @(negedge clk);
    @(negedge clk);
    check("b2b_idle", {31'd0, bus.busy}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multiply16.md
# multiply16

Sequential signed 16x16 radix-2 Booth multiplier. It is the inverse-operation companion to the `divide16` sequential divider and uses the same start/done control style and the same clk/rst conventions. It accepts two's-complement operands on a one-cycle `start`, retires one Booth step per clock, and presents a full-width 32-bit signed product with a one-cycle `done` pulse. It sits beside the divider in the arithmetic unit and is driven by the same controller.

## Interface
- `WIDTH`, default 16: operand width. The product width is 2*WIDTH. The step counter is wide enough to count WIDTH steps.
- `clk` input, 1 bit: single clock; all state changes on its rising edge.
- `rst` input, 1 bit: reset, synchronous and active-high.
- `start` input, 1 bit: operation request, sampled on the rising edge.
- `multiplicand` input, WIDTH bits: signed two's-complement operand.
- `multiplier` input, WIDTH bits: signed two's-complement operand.
- `product` output, 2*WIDTH bits: signed result, registered.
- `busy` output, 1 bit: high while an operation is in progress.
- `done` output, 1 bit: one-cycle completion pulse.

## Operation
- **States:**
  - IDLE: reset state.
  - RUN: Booth iteration.
  - DONE: one-cycle completion state.
- **Transitions:**
  - IDLE -> RUN on `start`=1.
  - DONE -> RUN on `start`=1.
  - DONE -> IDLE otherwise.
  - RUN -> DONE after WIDTH steps.
- **Load:** on the accepting edge, latch the registers as follows:
  - M = multiplicand, sign-extended to WIDTH+1 bits.
  - Q = multiplier.
  - q_-1 = 0.
  - A = 0, WIDTH+1 bits.
  - step counter = 0.
- After the load, the operand inputs are ignored until the next accepted `start`.
- **Booth step, per RUN cycle:** examine the pair {Q[0], q_-1}:
  - 01: A = A + M.
  - 10: A = A - M.
  - 00 and 11: A unchanged.
  - Then arithmetic-shift {A, Q, q_-1} right by one, replicating A's MSB. Increment the counter.
- **Width rule:** A is WIDTH+1 bits, so that -M with M = -2^(WIDTH-1) does not overflow. After the final step, `product` = {A[WIDTH-1:0], Q}.
- **Result:** the product is exact for all operand pairs. There is no overflow case. -32768 * -32768 = 0x40000000.
- **Start while busy:** `start` in RUN is ignored. The operation in flight is unaffected and no request is queued.
- **Start in DONE:** `start` in the DONE cycle is accepted. This allows back-to-back operations with no idle gap.
- **Product holding:** `product` is written only at the RUN -> DONE edge. It holds its value through IDLE and through the next RUN, until the next completion.
- **Reset:** `rst`=1 overrides everything, including mid-RUN.
  - Next state is IDLE.
  - `busy`=0, `done`=0, `product`=0, internal registers cleared.
  - A `start` in the same cycle as `rst` is dropped.

## Timing
- **Reset values:** `product`=0, `busy`=0, `done`=0.
- **Acceptance:** `start` is sampled at edge E. `busy` goes 1 after E.
- **Latency:**
  - Booth steps execute at edges E+1 .. E+WIDTH.
  - `product` is valid and `done`=1 after edge E+WIDTH; this is 16 cycles for WIDTH=16.
  - `busy` goes 0 at that same edge.
- **`done`:** high for exactly one cycle, then low at edge E+WIDTH+1 unless a new result completes.
- **Back-to-back:** `start` held high continuously yields one result every WIDTH+1 cycles.
- **`busy`:** equals (state == RUN). `busy` and `done` are never both high.
- **Registered outputs:** all outputs are registered, with no combinational path from inputs to outputs.

## Test plan
- **Basic signs:** 10*2, -15*3, -20*-4, 90*-7, each issued with a 1-cycle `start` pulse. Required responses:
  - `done` pulses exactly 16 cycles after the start edge.
  - `product` = 0x00000014, 0xFFFFFFD3, 0x00000050, 0xFFFFFD8A respectively.
- **Extremes:** -32768*-32768 -> 0x40000000; -32768*32767 -> 0xC0008000; 32767*32767 -> 0x3FFF0001; 0*1 -> 0, with `done` still asserted at 16 cycles.
- **Operand and start hygiene:** start 7*6, then change the operands and pulse `start` again mid-RUN.
  - Result is 0x0000002A at cycle 16.
  - Only one `done` pulse; `busy` stays high throughout.
- **Reset mid-operation:** start 1000*1000, assert `rst` at cycle 8.
  - Next cycle: `busy`=0, `done`=0, `product`=0.
  - A fresh 3*-3 then completes with 0xFFFFFFF7 16 cycles later.
- **Back-to-back:** `start` held high across two operations, 5*5 then -2*4 (operands switched at the DONE cycle).
  - Products are 0x19 and 0xFFFFFFF8.
  - `done` pulses 17 cycles apart.
  - `product` holds 0x19 until the second completion.
